// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO read-port to valid/ready stream adapter.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  localparam ptr_t LAST_PTR = ptr_t'(BUF_DEPTH - 1);
  localparam occ_t OCC_FULL = occ_t'(BUF_DEPTH);

  // Pointers walk 0,1,2,0,... and never hold 3.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_inc = (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry register buffer with wrapping read/write pointers; head word is
// presented combinationally from registered state.
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output occ_t             occupancy_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  ptr_t             wr_ptr_q;
  ptr_t             wr_ptr_d;
  ptr_t             rd_ptr_q;
  ptr_t             rd_ptr_d;
  occ_t             occ_q;
  occ_t             occ_d;
  logic             rd_fire;
  logic             wr_fire;

  // Next-state for pointers and occupancy; a full buffer only accepts a word
  // when the head leaves in the same cycle.
  always_comb begin
    rd_fire  = rd_en_i && (occ_q != 2'd0);
    wr_fire  = wr_en_i && ((occ_q != OCC_FULL) || rd_fire);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_fire) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_fire, rd_fire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage and bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

  assign valid_o     = (occ_q != 2'd0);
  assign rd_data_o   = valid_o ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Adapts a 1-cycle-latency FIFO read port to a valid/ready stream.
// Optional beat/stall counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occupancy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]      beat_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  logic       inflight_q;
  logic       inflight_d;
  logic [2:0] committed;
  logic       pop;
  occ_t       occ;

  // Issue a read only when buffered plus in-flight words leave room; m_ready
  // deliberately plays no part here.
  always_comb begin
    committed  = {1'b0, occ} + {2'b00, inflight_q};
    fifo_rd_en = !fifo_empty && !rd_rst && (committed < 3'(BUF_DEPTH));
    inflight_d = fifo_rd_en;
  end

  // Marks the cycle in which FIFO read data is valid.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign pop = m_valid && m_ready;

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i       (rd_clk),
    .rst_i       (rd_rst),
    .wr_en_i     (inflight_q),
    .wr_data_i   (fifo_data_out),
    .rd_en_i     (pop),
    .rd_data_o   (m_data),
    .valid_o     (m_valid),
    .occupancy_o (occ)
  );

  assign occupancy = occ;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] beat_q;
  logic [15:0] beat_d;
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    if (pop) begin
      beat_d = beat_q + 16'd1;
    end else begin
      beat_d = beat_q;
    end
    if (m_valid && !m_ready) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_q  <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      beat_q  <= beat_d;
      stall_q <= stall_d;
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out = 8'h00;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [1:0]       occupancy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0]      beat_cnt;
  logic [15:0]      stall_cnt;
`endif

  logic [WIDTH-1:0] fifo_mem [0:255];
  int               fifo_wr_idx = 0;
  int               fifo_rd_idx = 0;
  logic [WIDTH-1:0] sb_q [$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             stall_seen = 1'b0;
  logic [WIDTH-1:0] stall_data = 8'h00;

  fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .occupancy     (occupancy)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beat_cnt      (beat_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (fifo_rd_idx == fifo_wr_idx);

  // FIFO model: read data appears one cycle after fifo_rd_en
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_mem[fifo_rd_idx];
      fifo_rd_idx   <= fifo_rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_mem[fifo_wr_idx] = w;
    fifo_wr_idx++;
    sb_q.push_back(w);
  endtask

  // Words already popped from the FIFO are lost by a reset.
  task automatic trim_sb();
    while (sb_q.size() > (fifo_wr_idx - fifo_rd_idx)) begin
      void'(sb_q.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || m_valid) && t < 60) begin
      @(negedge rd_clk);
      t++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(occupancy), 32'd0);
  endtask

  // Delivery order, hold-while-stalled and full-buffer issue monitor
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      stall_seen <= 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_word", 32'(sb_q.size()), 32'd1);
        end else begin
          check("order", 32'(m_data), 32'(sb_q.pop_front()));
        end
      end
      if (occupancy == 2'd3) begin
        check("rd_en_when_full", 32'(fifo_rd_en), 32'd0);
      end
      stall_seen <= m_valid && !m_ready;
      stall_data <= m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int t;
    int run;
    rd_rst  = 1'b1;
    m_ready = 1'b1;

    @(negedge rd_clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    push(8'hA5);
    @(negedge rd_clk);
    check("rst_rd_en_nonempty", 32'(fifo_rd_en), 32'd0);

    // First read issues in the first cycle after reset release
    tick();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    check("first_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge rd_clk);
    check("first_rd_en_once", 32'(fifo_rd_en), 32'd0);
    check("first_lat_valid", 32'(m_valid), 32'd0);
    @(negedge rd_clk);
    check("first_valid", 32'(m_valid), 32'd1);
    check("first_data", 32'(m_data), 32'hA5);
    @(negedge rd_clk);
    check("first_occ0", 32'(occupancy), 32'd0);
    check("first_pops", 32'(fifo_rd_idx), 32'd1);

    // Single word from idle
    tick();
    base = fifo_rd_idx;
    push(8'h5A);
    @(negedge rd_clk);
    check("single_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge rd_clk);
    check("single_valid_n1", 32'(m_valid), 32'd0);
    @(negedge rd_clk);
    check("single_valid_n2", 32'(m_valid), 32'd1);
    check("single_data", 32'(m_data), 32'h5A);
    @(negedge rd_clk);
    check("single_occ0", 32'(occupancy), 32'd0);
    check("single_pops", 32'(fifo_rd_idx - base), 32'd1);

    // Streaming 16 words at full rate
    tick();
    for (int i = 0; i < 16; i++) push(8'(i));
    t = 0;
    @(negedge rd_clk);
    while (!m_valid && t < 10) begin
      @(negedge rd_clk);
      t++;
    end
    check("stream_start", 32'(m_valid), 32'd1);
    run = 0;
    while (m_valid && run < 20) begin
      run++;
      @(negedge rd_clk);
    end
    check("stream_run", 32'(run), 32'd16);
    check("stream_sb", 32'(sb_q.size()), 32'd0);

    // Backpressure fills the buffer and halts reads
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    repeat (8) @(negedge rd_clk);
    check("bp_occ", 32'(occupancy), 32'd3);
    check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    check("bp_data", 32'(m_data), 32'h20);
    check("bp_fifo_left", 32'(fifo_wr_idx - fifo_rd_idx), 32'd3);
    tick();
    m_ready = 1'b1;
    drain("bp_drain");

    // Alternating ready
    tick();
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    m_ready = 1'b0;
    for (int c = 0; c < 80 && (sb_q.size() != 0 || m_valid); c++) begin
      tick();
      m_ready = !m_ready;
    end
    check("alt_sb", 32'(sb_q.size()), 32'd0);
    m_ready = 1'b1;

    // Reset with two words buffered and one in flight
    tick();
    m_ready = 1'b0;
    base = fifo_rd_idx;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    tick();
    tick();
    tick();
    check("mid_occ2", 32'(occupancy), 32'd2);
    check("mid_popped", 32'(fifo_rd_idx - base), 32'd3);
    rd_rst = 1'b1;
    trim_sb();
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    tick();
    tick();
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    t = 0;
    @(negedge rd_clk);
    while (!m_valid && t < 10) begin
      @(negedge rd_clk);
      t++;
    end
    check("mid_next_valid", 32'(m_valid), 32'd1);
    check("mid_next_word", 32'(m_data), 32'h43);
    drain("mid_drain");

`ifdef FIFO_RD_STREAM_STATS_EN
    // 5 beats with exactly 3 stall cycles
    tick();
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    check("stats_rst_beat", 32'(beat_cnt), 32'd0);
    check("stats_rst_stall", 32'(stall_cnt), 32'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    tick();
    tick();
    check("stats_valid", 32'(m_valid), 32'd1);
    tick();
    tick();
    tick();
    m_ready = 1'b1;
    drain("stats_drain");
    check("stats_beat", 32'(beat_cnt), 32'd5);
    check("stats_stall", 32'(stall_cnt), 32'd3);
`endif

    repeat (2) @(negedge rd_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of the FIFO read port and the output stream.
REQ-002 SHALL have the following ports:
- rd_clk, input, 1 bit: the single clock, i.e. the FIFO read-domain clock.
- rd_rst, input, 1 bit: asynchronous, active-high reset.
- fifo_empty, input, 1 bit: the FIFO's empty flag.
- fifo_data_out, input, WIDTH bits: FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_rd_en, output, 1 bit: pops one word from the FIFO.
- m_valid, output, 1 bit: the output stream holds a word.
- m_data, output, WIDTH bits: the output stream word.
- m_ready, input, 1 bit: the consumer accepts the word.
- occupancy, output, 2 bits: number of words held internally, 0..3.
REQ-003 SHALL have one clock only; reset is asynchronous and active-high.

Function
REQ-004 SHALL convert the FIFO's 1-cycle-latency read port into a valid/ready stream through a 3-entry internal buffer.
REQ-005 SHALL compute fifo_rd_en = !fifo_empty && !rd_rst && (occupancy + inflight < 3), where inflight is a register set in the cycle after fifo_rd_en is asserted.
REQ-006 SHALL derive fifo_rd_en only from registered state, fifo_empty and rd_rst, with no combinational path from m_ready.
REQ-007 SHALL capture fifo_data_out at the rd_clk edge that ends the cycle in which inflight is 1.
REQ-008 SHALL transfer a word when m_valid && m_ready at a rising edge.
REQ-009 SHALL drive m_valid = (occupancy != 0), with m_data equal to the oldest buffered word.
REQ-010 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-011 SHALL have 2-cycle latency: if fifo_empty is low in cycle N with occupancy 0 and inflight 0, then fifo_rd_en is high in N and m_valid is high in N+2 carrying that word.
REQ-012 SHALL sustain one word per cycle when fifo_empty stays low and m_ready stays high.
REQ-013 SHALL, when a capture and a pop occur in the same cycle, leave occupancy unchanged and keep output order.
REQ-014 SHALL, when occupancy is 3, keep fifo_rd_en low, so that occupancy + inflight never exceeds 3 and overflow is impossible.
REQ-015 SHALL index the buffer with 2-bit read and write pointers that wrap from 2 to 0, never taking the value 3.
REQ-016 SHALL preserve word order exactly, with no loss or duplication.

Reset
REQ-017 SHALL, while rd_rst is high, clear occupancy, inflight and both pointers, drive m_valid=0, m_data=0 and fifo_rd_en=0.
REQ-018 SHALL, on reset mid-operation, discard buffered and in-flight words, and ignore FIFO data arriving in the cycle after reset.
REQ-019 SHALL be able to issue the first fifo_rd_en in the first cycle after rd_rst deasserts.

Configuration
REQ-020 SHALL, with macro FIFO_RD_STREAM_STATS_EN defined, add these outputs, reset to 0 by rd_rst:
- beat_cnt, 16 bits: counts accepted transfers and wraps at 65535->0.
- stall_cnt, 16 bits: counts cycles with m_valid && !m_ready and wraps.
REQ-021 SHALL, without FIFO_RD_STREAM_STATS_EN, omit beat_cnt, stall_cnt and their logic entirely.

Structure
REQ-022 SHALL place in package fifo_rd_stream_pkg:
- constant BUF_DEPTH = 3;
- the occupancy typedef (2-bit unsigned);
- the pointer typedef (2-bit unsigned).
REQ-023 SHALL implement the 3-entry register storage and pointers in sub-module fifo_rd_skid_buf, with the top level holding the issue logic, inflight and stats.

Verification
REQ-024 SHALL cover single word: push 8'hA5 into the FIFO with m_ready=1; fifo_rd_en pulses once, m_valid is high 2 cycles after empty falls with m_data=8'hA5, and occupancy returns to 0.
REQ-025 SHALL cover streaming: 16 words 8'h00..8'h0F with m_ready=1; after the first word, m_valid is high for 16 consecutive cycles and the data appear in order.
REQ-026 SHALL cover backpressure: m_ready=0 with the FIFO non-empty; occupancy reaches 3, fifo_rd_en stays 0 and m_data holds the first word; releasing m_ready drains in order with no loss.
REQ-027 SHALL cover alternating m_ready 1/0 over 10 words: every word is delivered once, in order, and m_data is stable while stalled.
REQ-028 SHALL cover reset mid-stream: assert rd_rst with occupancy 2 and inflight 1; m_valid=0 and fifo_rd_en=0 immediately, and after release the next delivered word is the next FIFO word.
REQ-029 SHALL, with FIFO_RD_STREAM_STATS_EN, cover 5 transfers and 3 stall cycles giving beat_cnt=5 and stall_cnt=3.
